// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - ROM/RAM handshake bundle between the control unit and the memories
interface control_unit_if;
    logic instruction_busy;
    logic data_mem_busy;
    logic instruction_mem_enable;
    logic data_mem_enable;
    logic data_mem_write_enable;

    modport master (
        input  instruction_busy,
        input  data_mem_busy,
        output instruction_mem_enable,
        output data_mem_enable,
        output data_mem_write_enable
    );

    modport slave (
        output instruction_busy,
        output data_mem_busy,
        input  instruction_mem_enable,
        input  data_mem_enable,
        input  data_mem_write_enable
    );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle RV64I control unit; RV64I_EN enables W ops and LD/SD
module control_unit (
    input  logic                 clock,
    input  logic                 reset,
    control_unit_if.master       mem,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7,
    input  logic                 zero,
    input  logic                 negative,
    input  logic                 carry_out,
    input  logic                 overflow,
    output logic                 alua_src,
    output logic                 alub_src,
    output logic                 aluy_src,
    output logic [2:0]           alu_src,
    output logic                 carry_in,
    output logic                 arithmetic,
    output logic                 alupc_src,
    output logic                 pc_src,
    output logic                 pc_enable,
    output logic [2:0]           read_data_src,
    output logic [1:0]           write_register_src,
    output logic                 write_register_enable,
    output logic                 halt
);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
`ifdef RV64I_EN
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic       WIDE_MEM     = 1'b1;
`else
    localparam logic       WIDE_MEM     = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        WAIT_FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WAIT_MEM,
        WRITEBACK,
        HALTED
    } state_t;

    state_t state;

    logic fetch_q;
    logic mem_q;
    logic mem_write_q;

    logic is_mem;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic illegal;
    logic branch_taken;

    assign mem.instruction_mem_enable = fetch_q;
    assign mem.data_mem_enable        = mem_q;
    assign mem.data_mem_write_enable  = mem_write_q;

    // Branch condition from the flags of A + ~B + 1
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = ~zero;
            3'b100:  branch_taken = negative ^ overflow;
            3'b101:  branch_taken = ~(negative ^ overflow);
            3'b110:  branch_taken = ~carry_out;
            3'b111:  branch_taken = carry_out;
            default: branch_taken = 1'b0;
        endcase
    end

    // Instruction decode: datapath selectors and the class flags used by the FSM
    always_comb begin
        alua_src           = 1'b0;
        alub_src           = 1'b0;
        aluy_src           = 1'b0;
        alu_src            = 3'b000;
        carry_in           = 1'b0;
        arithmetic         = 1'b0;
        alupc_src          = 1'b0;
        pc_src             = 1'b0;
        read_data_src      = 3'b000;
        write_register_src = 2'b00;
        is_mem             = 1'b0;
        is_load            = 1'b0;
        is_store           = 1'b0;
        is_branch          = 1'b0;
        illegal            = 1'b0;
        case (opcode)
`ifdef RV64I_EN
            OPC_OP, OPC_OP_IMM, OPC_OP32, OPC_OP_IMM32: begin
`else
            OPC_OP, OPC_OP_IMM: begin
`endif
                // opcode[5] separates register forms from immediate forms
                alu_src  = funct3;
                alub_src = ~opcode[5];
                carry_in = (funct3 == 3'b010) || (funct3 == 3'b011) ||
                           (opcode[5] && funct3 == 3'b000 && funct7);
                if (funct3 == 3'b101)
                    arithmetic = funct7;
                else if (opcode[5] && funct3 == 3'b000)
                    arithmetic = funct7;
`ifdef RV64I_EN
                // opcode[3] marks the 32-bit W variants
                aluy_src = opcode[3];
`endif
            end
            OPC_LUI: begin
                write_register_src = 2'b11;
            end
            OPC_AUIPC: begin
                alua_src = 1'b1;
                alub_src = 1'b1;
            end
            OPC_JAL: begin
                pc_src             = 1'b1;
                write_register_src = 2'b10;
            end
            OPC_JALR: begin
                pc_src             = 1'b1;
                alupc_src          = 1'b1;
                write_register_src = 2'b10;
            end
            OPC_LOAD: begin
                alub_src           = 1'b1;
                read_data_src      = funct3;
                write_register_src = 2'b01;
                is_mem             = 1'b1;
                is_load            = 1'b1;
                illegal            = (funct3 == 3'b011) && !WIDE_MEM;
            end
            OPC_STORE: begin
                alub_src      = 1'b1;
                read_data_src = funct3;
                is_mem        = 1'b1;
                is_store      = 1'b1;
                illegal       = (funct3 == 3'b011) && !WIDE_MEM;
            end
            OPC_BRANCH: begin
                carry_in  = 1'b1;
                pc_src    = branch_taken;
                is_branch = 1'b1;
                illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // Sequencer; each strobe is registered alongside the state it belongs to
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                 <= IDLE;
            fetch_q               <= 1'b0;
            mem_q                 <= 1'b0;
            mem_write_q           <= 1'b0;
            pc_enable             <= 1'b0;
            write_register_enable <= 1'b0;
            halt                  <= 1'b0;
        end else begin
            fetch_q               <= 1'b0;
            mem_q                 <= 1'b0;
            mem_write_q           <= 1'b0;
            pc_enable             <= 1'b0;
            write_register_enable <= 1'b0;
            halt                  <= 1'b0;
            case (state)
                IDLE: begin
                    state   <= FETCH;
                    fetch_q <= 1'b1;
                end
                FETCH: begin
                    state <= WAIT_FETCH;
                end
                WAIT_FETCH: begin
                    if (!mem.instruction_busy)
                        state <= DECODE;
                end
                DECODE: begin
                    if (illegal) begin
                        state <= HALTED;
                        halt  <= 1'b1;
                    end else if (is_mem) begin
                        state       <= MEM;
                        mem_q       <= 1'b1;
                        mem_write_q <= is_store;
                    end else begin
                        state                 <= EXECUTE;
                        pc_enable             <= 1'b1;
                        write_register_enable <= ~is_branch;
                    end
                end
                EXECUTE: begin
                    state   <= FETCH;
                    fetch_q <= 1'b1;
                end
                MEM: begin
                    state <= WAIT_MEM;
                end
                WAIT_MEM: begin
                    if (!mem.data_mem_busy) begin
                        state                 <= WRITEBACK;
                        pc_enable             <= 1'b1;
                        write_register_enable <= is_load;
                    end
                end
                WRITEBACK: begin
                    state   <= FETCH;
                    fetch_q <= 1'b1;
                end
                HALTED: begin
                    state <= HALTED;
                    halt  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized self-checking bench for control_unit
module tb_control_unit;

    localparam int K_ALU = 0, K_JUMP = 1, K_BR = 2, K_LD = 3, K_ST = 4;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [11:0] sel;
        int         kind;
    } instr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7 = 1'b0;
    logic        zero = 1'b0, negative = 1'b0, carry_out = 1'b0, overflow = 1'b0;
    logic        alua_src, alub_src, aluy_src, carry_in, arithmetic, alupc_src, pc_src;
    logic        pc_enable, write_register_enable, halt;
    logic [2:0]  alu_src, read_data_src;
    logic [1:0]  write_register_src;

    int checks = 0;
    int errors = 0;
    int rom_cnt = 0, ram_cnt = 0, rom_time = 0, ram_time = 0;
    instr_t tbl[$];

    control_unit_if mem_if ();

    control_unit dut (
        .clock                 (clock),
        .reset                 (reset),
        .mem                   (mem_if),
        .opcode                (opcode),
        .funct3                (funct3),
        .funct7                (funct7),
        .zero                  (zero),
        .negative              (negative),
        .carry_out             (carry_out),
        .overflow              (overflow),
        .alua_src              (alua_src),
        .alub_src              (alub_src),
        .aluy_src              (aluy_src),
        .alu_src               (alu_src),
        .carry_in              (carry_in),
        .arithmetic            (arithmetic),
        .alupc_src             (alupc_src),
        .pc_src                (pc_src),
        .pc_enable             (pc_enable),
        .read_data_src         (read_data_src),
        .write_register_src    (write_register_src),
        .write_register_enable (write_register_enable),
        .halt                  (halt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {mem_if.instruction_mem_enable, mem_if.data_mem_enable,
                mem_if.data_mem_write_enable, pc_enable, write_register_enable, halt};
    endfunction

    function automatic logic [11:0] selectors();
        return {alua_src, alub_src, aluy_src, alu_src, carry_in, arithmetic,
                alupc_src, pc_src, write_register_src};
    endfunction

    function automatic logic [11:0] s(input logic alua, input logic alub, input logic aluy,
                                      input logic [2:0] alu, input logic cin, input logic arith,
                                      input logic alupc, input logic pcs, input logic [1:0] wrs);
        return {alua, alub, aluy, alu, cin, arith, alupc, pcs, wrs};
    endfunction

    function automatic instr_t mk(input string name, input logic [6:0] op, input logic [2:0] f3,
                                  input logic f7, input logic [11:0] sel, input int kind);
        instr_t e;
        e.name = name; e.op = op; e.f3 = f3; e.f7 = f7; e.sel = sel; e.kind = kind;
        return e;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'd2;
            3: return '1;
            4: return 64'h8000_0000_0000_0000;
            5: return 64'h7fff_ffff_ffff_ffff;
            6: return {$urandom, $urandom};
            default: return 64'hffff_ffff_ffff_fffe;
        endcase
    endfunction

    function automatic int pick_busy();
        case ($urandom_range(0, 4))
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 3;
            default: return 12;
        endcase
    endfunction

    // Advance to the middle of the next cycle; ROM/RAM raise busy the cycle after a strobe
    task automatic cycle();
        @(negedge clock);
        mem_if.instruction_busy = (rom_cnt > 0);
        if (rom_cnt > 0) rom_cnt--;
        if (mem_if.instruction_mem_enable) rom_cnt = rom_time;
        mem_if.data_mem_busy = (ram_cnt > 0);
        if (ram_cnt > 0) ram_cnt--;
        if (mem_if.data_mem_enable) ram_cnt = ram_time;
    endtask

    task automatic clear_mem();
        rom_cnt = 0;
        ram_cnt = 0;
        mem_if.instruction_busy = 1'b0;
        mem_if.data_mem_busy = 1'b0;
    endtask

    // Reset is released mid-cycle; IDLE occupies the rest of it, FETCH follows
    task automatic release_reset();
        @(negedge clock);
        reset = 1'b1;
        #1 check("idle after release", 32'(strobes()), 32'd0);
    endtask

    task automatic assert_reset(input string tag);
        #2 reset = 1'b0;
        #1 check({tag, " async reset strobes"}, 32'(strobes()), 32'd0);
        clear_mem();
        cycle();
        cycle();
    endtask

    task automatic run_instr(input instr_t e, input logic [63:0] a, input logic [63:0] b,
                             input int rb, input int mb);
        logic [63:0] d;
        logic        taken;
        logic [5:0]  exp_q[$];
        logic [11:0] exp_sel;
        bit          is_mem;
        int          dec_idx;
        d = a - b;
        opcode = e.op; funct3 = e.f3; funct7 = e.f7;
        zero = (d == 64'd0);
        negative = d[63];
        carry_out = (a >= b);
        overflow = (a[63] != b[63]) && (d[63] != a[63]);
        case (e.f3)
            3'd0: taken = (a == b);
            3'd1: taken = (a != b);
            3'd4: taken = ($signed(a) < $signed(b));
            3'd5: taken = ($signed(a) >= $signed(b));
            3'd6: taken = (a < b);
            default: taken = (a >= b);
        endcase
        exp_sel = e.sel | ((e.kind == K_BR && taken) ? 12'h004 : 12'h000);
        rom_time = rb;
        ram_time = mb;
        is_mem = (e.kind == K_LD) || (e.kind == K_ST);
        exp_q.push_back(6'b100000);
        repeat (rb + 1) exp_q.push_back(6'b000000);
        exp_q.push_back(6'b000000);
        dec_idx = rb + 2;
        if (is_mem) begin
            exp_q.push_back({2'b01, e.kind == K_ST, 3'b000});
            repeat (mb + 1) exp_q.push_back(6'b000000);
            exp_q.push_back({4'b0001, e.kind == K_LD, 1'b0});
        end else begin
            exp_q.push_back({4'b0001, e.kind != K_BR, 1'b0});
        end
        foreach (exp_q[i]) begin
            cycle();
            check($sformatf("%s strobes c%0d", e.name, i), 32'(strobes()), 32'(exp_q[i]));
            if (i == dec_idx)
                check($sformatf("%s selectors", e.name), 32'(selectors()), 32'(exp_sel));
            if (is_mem && i == dec_idx + 1)
                check($sformatf("%s read_data_src", e.name), 32'(read_data_src), 32'(e.f3));
        end
    endtask

    task automatic run_illegal(input string name, input logic [6:0] op, input logic [2:0] f3,
                               input logic f7, input int rb);
        logic [5:0] exp_q[$];
        opcode = op; funct3 = f3; funct7 = f7;
        rom_time = rb;
        exp_q.push_back(6'b100000);
        repeat (rb + 2) exp_q.push_back(6'b000000);
        repeat (5) exp_q.push_back(6'b000001);
        foreach (exp_q[i]) begin
            cycle();
            check($sformatf("%s halt c%0d", name, i), 32'(strobes()), 32'(exp_q[i]));
        end
        assert_reset(name);
        release_reset();
    endtask

    initial begin
        instr_t e;
        tbl.push_back(mk("ADD",   7'b0110011, 3'd0, 1'b0, s(0,0,0,3'd0,0,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("SUB",   7'b0110011, 3'd0, 1'b1, s(0,0,0,3'd0,1,1,0,0,2'd0), K_ALU));
        tbl.push_back(mk("SLL",   7'b0110011, 3'd1, 1'b0, s(0,0,0,3'd1,0,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("SLT",   7'b0110011, 3'd2, 1'b0, s(0,0,0,3'd2,1,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("SLTU",  7'b0110011, 3'd3, 1'b0, s(0,0,0,3'd3,1,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("XOR",   7'b0110011, 3'd4, 1'b0, s(0,0,0,3'd4,0,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("SRL",   7'b0110011, 3'd5, 1'b0, s(0,0,0,3'd5,0,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("SRA",   7'b0110011, 3'd5, 1'b1, s(0,0,0,3'd5,0,1,0,0,2'd0), K_ALU));
        tbl.push_back(mk("OR",    7'b0110011, 3'd6, 1'b0, s(0,0,0,3'd6,0,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("AND",   7'b0110011, 3'd7, 1'b0, s(0,0,0,3'd7,0,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("ADDI",  7'b0010011, 3'd0, 1'b0, s(0,1,0,3'd0,0,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("ADDIn", 7'b0010011, 3'd0, 1'b1, s(0,1,0,3'd0,0,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("SLTI",  7'b0010011, 3'd2, 1'b0, s(0,1,0,3'd2,1,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("SLTIU", 7'b0010011, 3'd3, 1'b1, s(0,1,0,3'd3,1,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("XORI",  7'b0010011, 3'd4, 1'b1, s(0,1,0,3'd4,0,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("ORI",   7'b0010011, 3'd6, 1'b0, s(0,1,0,3'd6,0,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("ANDI",  7'b0010011, 3'd7, 1'b1, s(0,1,0,3'd7,0,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("SLLI",  7'b0010011, 3'd1, 1'b0, s(0,1,0,3'd1,0,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("SRLI",  7'b0010011, 3'd5, 1'b0, s(0,1,0,3'd5,0,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("SRAI",  7'b0010011, 3'd5, 1'b1, s(0,1,0,3'd5,0,1,0,0,2'd0), K_ALU));
        tbl.push_back(mk("LUI",   7'b0110111, 3'd0, 1'b0, s(0,0,0,3'd0,0,0,0,0,2'd3), K_ALU));
        tbl.push_back(mk("AUIPC", 7'b0010111, 3'd0, 1'b0, s(1,1,0,3'd0,0,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("JAL",   7'b1101111, 3'd0, 1'b0, s(0,0,0,3'd0,0,0,0,1,2'd2), K_JUMP));
        tbl.push_back(mk("JALR",  7'b1100111, 3'd0, 1'b0, s(0,0,0,3'd0,0,0,1,1,2'd2), K_JUMP));
        tbl.push_back(mk("BEQ",   7'b1100011, 3'd0, 1'b0, s(0,0,0,3'd0,1,0,0,0,2'd0), K_BR));
        tbl.push_back(mk("BNE",   7'b1100011, 3'd1, 1'b0, s(0,0,0,3'd0,1,0,0,0,2'd0), K_BR));
        tbl.push_back(mk("BLT",   7'b1100011, 3'd4, 1'b0, s(0,0,0,3'd0,1,0,0,0,2'd0), K_BR));
        tbl.push_back(mk("BGE",   7'b1100011, 3'd5, 1'b0, s(0,0,0,3'd0,1,0,0,0,2'd0), K_BR));
        tbl.push_back(mk("BLTU",  7'b1100011, 3'd6, 1'b0, s(0,0,0,3'd0,1,0,0,0,2'd0), K_BR));
        tbl.push_back(mk("BGEU",  7'b1100011, 3'd7, 1'b0, s(0,0,0,3'd0,1,0,0,0,2'd0), K_BR));
        tbl.push_back(mk("LB",    7'b0000011, 3'd0, 1'b0, s(0,1,0,3'd0,0,0,0,0,2'd1), K_LD));
        tbl.push_back(mk("LH",    7'b0000011, 3'd1, 1'b0, s(0,1,0,3'd0,0,0,0,0,2'd1), K_LD));
        tbl.push_back(mk("LW",    7'b0000011, 3'd2, 1'b0, s(0,1,0,3'd0,0,0,0,0,2'd1), K_LD));
        tbl.push_back(mk("LBU",   7'b0000011, 3'd4, 1'b0, s(0,1,0,3'd0,0,0,0,0,2'd1), K_LD));
        tbl.push_back(mk("LHU",   7'b0000011, 3'd5, 1'b0, s(0,1,0,3'd0,0,0,0,0,2'd1), K_LD));
        tbl.push_back(mk("SB",    7'b0100011, 3'd0, 1'b0, s(0,1,0,3'd0,0,0,0,0,2'd0), K_ST));
        tbl.push_back(mk("SH",    7'b0100011, 3'd1, 1'b0, s(0,1,0,3'd0,0,0,0,0,2'd0), K_ST));
        tbl.push_back(mk("SW",    7'b0100011, 3'd2, 1'b0, s(0,1,0,3'd0,0,0,0,0,2'd0), K_ST));
`ifdef RV64I_EN
        tbl.push_back(mk("LD",    7'b0000011, 3'd3, 1'b0, s(0,1,0,3'd0,0,0,0,0,2'd1), K_LD));
        tbl.push_back(mk("SD",    7'b0100011, 3'd3, 1'b0, s(0,1,0,3'd0,0,0,0,0,2'd0), K_ST));
        tbl.push_back(mk("ADDIW", 7'b0011011, 3'd0, 1'b0, s(0,1,1,3'd0,0,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("SLLIW", 7'b0011011, 3'd1, 1'b0, s(0,1,1,3'd1,0,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("SRLIW", 7'b0011011, 3'd5, 1'b0, s(0,1,1,3'd5,0,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("SRAIW", 7'b0011011, 3'd5, 1'b1, s(0,1,1,3'd5,0,1,0,0,2'd0), K_ALU));
        tbl.push_back(mk("ADDW",  7'b0111011, 3'd0, 1'b0, s(0,0,1,3'd0,0,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("SUBW",  7'b0111011, 3'd0, 1'b1, s(0,0,1,3'd0,1,1,0,0,2'd0), K_ALU));
        tbl.push_back(mk("SLLW",  7'b0111011, 3'd1, 1'b0, s(0,0,1,3'd1,0,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("SRLW",  7'b0111011, 3'd5, 1'b0, s(0,0,1,3'd5,0,0,0,0,2'd0), K_ALU));
        tbl.push_back(mk("SRAW",  7'b0111011, 3'd5, 1'b1, s(0,0,1,3'd5,0,1,0,0,2'd0), K_ALU));
`endif

        clear_mem();
        repeat (2) cycle();
        check("reset strobes", 32'(strobes()), 32'd0);
        release_reset();

        run_instr(mk("ADDI x1", 7'b0010011, 3'd0, 1'b0, s(0,1,0,3'd0,0,0,0,0,2'd0), K_ALU),
                  64'd0, 64'd0, 12, 0);
        e = mk("BLTU", 7'b1100011, 3'd6, 1'b0, s(0,0,0,3'd0,1,0,0,0,2'd0), K_BR);
        run_instr(e, 64'd1, 64'd2, 0, 0);
        run_instr(e, 64'd2, 64'd1, 0, 0);
        run_instr(mk("LW", 7'b0000011, 3'd2, 1'b0, s(0,1,0,3'd0,0,0,0,0,2'd1), K_LD),
                  64'd0, 64'd0, 0, 12);
        run_instr(mk("SW", 7'b0100011, 3'd2, 1'b0, s(0,1,0,3'd0,0,0,0,0,2'd0), K_ST),
                  64'd0, 64'd0, 0, 12);

        for (int n = 0; n < 60; n++) begin
            logic [63:0] a, b;
            a = pick();
            b = ($urandom_range(0, 3) == 0) ? a : pick();
            run_instr(tbl[$urandom_range(0, tbl.size() - 1)], a, b, pick_busy(), pick_busy());
        end

        // Reset in the middle of a fetch wait abandons it and restarts cleanly
        opcode = 7'b0010011; funct3 = 3'd0; funct7 = 1'b0;
        rom_time = 12;
        cycle();
        check("midwait fetch", 32'(strobes()), 32'h20);
        repeat (3) begin
            cycle();
            check("midwait quiet", 32'(strobes()), 32'd0);
        end
        assert_reset("midwait");
        release_reset();
        run_instr(mk("ADDI post", 7'b0010011, 3'd0, 1'b0, s(0,1,0,3'd0,0,0,0,0,2'd0), K_ALU),
                  64'd0, 64'd0, 0, 0);

        run_illegal("OP7F", 7'b1111111, 3'd0, 1'b0, 2);
        run_illegal("BR010", 7'b1100011, 3'd2, 1'b0, 0);
        run_illegal("BR011", 7'b1100011, 3'd3, 1'b0, 1);
        run_illegal("FENCE", 7'b0001111, 3'd0, 1'b0, 0);
`ifdef RV64I_EN
        run_instr(mk("ADDW x", 7'b0111011, 3'd0, 1'b0, s(0,0,1,3'd0,0,0,0,0,2'd0), K_ALU),
                  64'd3, 64'd4, 0, 0);
`else
        run_illegal("ADDW", 7'b0111011, 3'd0, 1'b0, 0);
        run_illegal("ADDIW", 7'b0011011, 3'd0, 1'b0, 0);
        run_illegal("LD", 7'b0000011, 3'd3, 1'b0, 0);
        run_illegal("SD", 7'b0100011, 3'd3, 1'b0, 0);
`endif
        run_instr(mk("ADD end", 7'b0110011, 3'd0, 1'b0, s(0,0,0,3'd0,0,0,0,0,2'd0), K_ALU),
                  64'd5, 64'd5, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
